brg: RTL and testbench

BRG -- requirements
Module: brg

---
 rtl/brg.sv | 61 ++++++
 tb/tb_brg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/brg.sv
// Baud-rate generator: a 16-bit programmable divisor drives a down-counter that
// emits a one-cycle registered enable strobe once every DIV clock cycles.
module brg (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_ioaddr_brg,
    input  logic [7:0] i_brg_bus,
    output logic       en
);

    localparam logic [1:0] ADDR_DB_LO = 2'b10;
    localparam logic [1:0] ADDR_DB_HI = 2'b11;

    logic [7:0]  db_lo;
    logic [7:0]  db_hi;
    logic [15:0] cnt;
    logic [15:0] div;
    logic [15:0] new_div;
    logic        div_write;

    assign div       = {db_hi, db_lo};
    assign div_write = (i_ioaddr_brg == ADDR_DB_LO) || (i_ioaddr_brg == ADDR_DB_HI);

    // Divisor as it will look after this edge's write, so the reload uses the fresh value
    always_comb begin
        new_div = div;
        if (i_ioaddr_brg == ADDR_DB_LO) begin
            new_div[7:0] = i_brg_bus;
        end else if (i_ioaddr_brg == ADDR_DB_HI) begin
            new_div[15:8] = i_brg_bus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_lo <= 8'h00;
            db_hi <= 8'h00;
            cnt   <= 16'h0000;
            en    <= 1'b0;
        end else if (div_write) begin
            if (i_ioaddr_brg == ADDR_DB_HI) begin
                db_hi <= i_brg_bus;
            end else begin
                db_lo <= i_brg_bus;
            end
            // A zero divisor parks the counter at 0 rather than wrapping to 0xFFFF
            cnt <= (new_div == 16'h0000) ? 16'h0000 : new_div - 16'd1;
            en  <= 1'b0;
        end else if (div == 16'h0000) begin
            cnt <= 16'h0000;
            en  <= 1'b0;
        end else if (cnt == 16'h0000) begin
            cnt <= div - 16'd1;
            en  <= 1'b1;
        end else begin
            cnt <= cnt - 16'd1;
            en  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_brg.sv
// Scoreboard bench for brg: the driver predicts en from a modular-arithmetic model
// and queues it; an independent monitor pops one expectation per clock edge.
module tb_brg;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] addr;
    logic [7:0] bus;
    logic       en;

    int    check_count = 0;
    int    fail_count  = 0;
    bit    exp_q[$];
    string phase = "init";

    int m_lo    = 0;
    int m_hi    = 0;
    int m_since = 0;

    brg dut (
        .clk          (clk),
        .rst          (rst),
        .i_ioaddr_brg (addr),
        .i_brg_bus    (bus),
        .en           (en)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        check_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: en=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: en pulses when a whole number of divisor periods has elapsed since the last write
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
        int div;
        bit e;
        @(negedge clk);
        addr = a;
        bus  = d;
        if (a[1]) begin
            if (a[0]) m_hi = d;
            else      m_lo = d;
            m_since = 0;
            e = 1'b0;
        end else begin
            m_since++;
            div = m_hi * 256 + m_lo;
            e = (div != 0) && (m_since % div == 0);
        end
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(2'($urandom_range(0, 1)), 8'($urandom));
        end
    endtask

    task automatic program_div(input logic [15:0] v, input bit hi_first);
        if (hi_first) begin
            applyStimulus(2'b11, v[15:8]);
            applyStimulus(2'b10, v[7:0]);
        end else begin
            applyStimulus(2'b10, v[7:0]);
            applyStimulus(2'b11, v[15:8]);
        end
    endtask

    // Monitor: one expectation per active edge, sampled just after the edge
    always @(posedge clk) begin
        bit e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(phase, en, e);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        addr = 2'b00;
        bus  = 8'h00;
        #1 rst = 1'b0;
        #2 checkOutput("reset_initial", en, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        phase = "idle_after_reset";
        idle(2000);
        phase = "program_zero";
        program_div(16'h0000, 1'b1);
        idle(50);

        phase = "div_651";
        program_div(16'h028B, 1'b1);
        for (int i = 0; i < 3 * 651; i++) applyStimulus(2'b00, 8'hFF);

        phase = "midperiod_lo_write";
        idle(200);
        applyStimulus(2'b10, 8'h10);
        idle(3 * 528 + 10);

        phase = "div_4";
        program_div(16'h0004, 1'b0);
        idle(40);

        phase = "div_2";
        program_div(16'h0002, 1'b1);
        idle(20);

        phase = "held_write";
        for (int i = 0; i < 10; i++) applyStimulus(2'b10, 8'h01);
        idle(10);

        phase = "random_small_div";
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 24))
                0:       applyStimulus(2'b10, 8'($urandom_range(0, 9)));
                1:       applyStimulus(2'b11, 8'h00);
                default: applyStimulus(2'($urandom_range(0, 1)), 8'($urandom));
            endcase
        end

        phase = "div_1";
        program_div(16'h0001, 1'b1);
        idle(30);

        @(posedge clk);
        #2;
        checkOutput("pre_reset_high", en, 1'b1);
        rst = 1'b0;
        #1 checkOutput("async_reset_drop", en, 1'b0);
        m_lo = 0;
        m_hi = 0;
        m_since = 0;
        repeat (2) @(posedge clk);
        #1 checkOutput("held_in_reset", en, 1'b0);
        @(negedge clk) rst = 1'b1;

        phase = "after_midrun_reset";
        idle(300);
        phase = "reprogram";
        program_div(16'h0003, 1'b0);
        idle(30);

        @(negedge clk);
        check_count++;
        if (exp_q.size() != 0) begin
            fail_count++;
            $display("[TB] FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", check_count - fail_count, check_count);
        $finish;
    end

endmodule
